alu_dispatch: RTL and testbench

Upstream sequencer for the ALU operation units (AND, OR, ADD, ...). It accepts one operation request per transaction and issues a one-cycle start to the selected unit. It holds the operands stable until that unit's done pulse arrives, then captures the 16-bit result and derives status flags. The result is returned over a valid/ready response handshake. A watchdog converts a missing done into an error response, so a dead unit cannot hang the datapath.

---
 rtl/alu_dispatch.sv | 169 ++++++++++++++++
 tb/tb_alu_dispatch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// ============================================================================
// Module   : alu_dispatch
// Purpose  : Sequences one request at a time to an attached ALU unit, waits for
//            its done pulse (with a watchdog) and returns result plus flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_dispatch #(
    parameter int NUM_UNITS = 6,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [7:0]             req_a,
    input  logic [7:0]             req_b,
    output logic [NUM_UNITS-1:0]   unit_start,
    output logic [7:0]             unit_a,
    output logic [7:0]             unit_b,
    input  logic [NUM_UNITS-1:0]   unit_done,
    input  logic [16*NUM_UNITS-1:0] unit_res,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_res,
    output logic                   rsp_zero,
    output logic                   rsp_neg,
    output logic                   rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    state_t                 r_state;
    logic [2:0]             r_op;
    logic [7:0]             r_a;
    logic [7:0]             r_b;
    logic [7:0]             r_timer;
    logic [NUM_UNITS-1:0]   r_start;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [15:0]            r_rsp_res;
    logic                   r_rsp_zero;
    logic                   r_rsp_neg;
    logic                   r_rsp_err;

    logic [NUM_UNITS-1:0]   w_req_onehot;
    logic                   w_op_ok;
    logic                   w_sel_done;
    logic [15:0]            w_sel_res;
    logic [7:0]             w_timer_inc;

    // Request decode and selection of the in-flight unit's done/result lane;
    // lanes of every other unit never reach the capture logic.
    always_comb begin
        w_req_onehot = '0;
        w_op_ok      = 1'b0;
        w_sel_done   = 1'b0;
        w_sel_res    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (req_op == 3'(i)) begin
                w_req_onehot[i] = 1'b1;
                w_op_ok         = 1'b1;
            end
            if (r_op == 3'(i)) begin
                w_sel_done = unit_done[i];
                w_sel_res  = unit_res[16*i +: 16];
            end
        end
    end

    assign w_timer_inc = r_timer + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_timer     <= '0;
            r_start     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_neg   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_req_ready <= 1'b0;
                        if (w_op_ok) begin
                            r_start <= w_req_onehot;
                            r_state <= S_ISSUE;
                        end else begin
                            r_rsp_res   <= '0;
                            r_rsp_zero  <= 1'b0;
                            r_rsp_neg   <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    r_start <= '0;
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so a coincident timeout still returns data.
                    if (w_sel_done) begin
                        r_rsp_res   <= w_sel_res;
                        r_rsp_zero  <= (w_sel_res == 16'd0);
                        r_rsp_neg   <= w_sel_res[15];
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= w_timer_inc;
                        if (w_timer_inc == c_timer_last) begin
                            r_rsp_res   <= '0;
                            r_rsp_zero  <= 1'b0;
                            r_rsp_neg   <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign unit_start = r_start;
    assign unit_a     = r_a;
    assign unit_b     = r_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_res    = r_rsp_res;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_neg    = r_rsp_neg;
    assign rsp_err    = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_dispatch.sv
// ============================================================================
// Module   : tb_alu_dispatch
// Purpose  : Self-checking bench for alu_dispatch with behavioural unit models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_dispatch;

    localparam int NU    = 6;
    localparam int TO    = 16;
    localparam int NEVER = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = '0;
    logic [7:0]        req_a = '0;
    logic [7:0]        req_b = '0;
    logic [NU-1:0]     unit_start;
    logic [7:0]        unit_a;
    logic [7:0]        unit_b;
    logic [NU-1:0]     unit_done = '0;
    logic [16*NU-1:0]  unit_res = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [15:0]       rsp_res;
    logic              rsp_zero;
    logic              rsp_neg;
    logic              rsp_err;

    int n_vec = 0;
    int n_mis = 0;

    // Unit model controls
    int          m_lat = 3;
    logic        m_ovr_en = 1'b0;
    logic [15:0] m_ovr_res = '0;
    int          mdl_idx;
    logic [15:0] mdl_r;

    alu_dispatch #(.NUM_UNITS(NU), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .unit_start (unit_start),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_done  (unit_done),
        .unit_res   (unit_res),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] unit_fn(input int idx, input logic [7:0] a, input logic [7:0] b);
        case (idx)
            0:       return {8'h00, a & b};
            1:       return {8'h00, a | b};
            2:       return {8'h00, a} + {8'h00, b};
            3:       return {8'h00, a ^ b};
            4:       return {8'h00, a} - {8'h00, b};
            default: return 16'(a) * 16'(b);
        endcase
    endfunction

    // Operation units: sample start, fire a decoy done on a neighbouring unit,
    // then raise their own done m_lat edges after seeing start.
    always begin
        @(posedge clk);
        if (reset && (unit_start != '0) && (m_lat != NEVER)) begin
            mdl_idx = 0;
            for (int i = 0; i < NU; i++) if (unit_start[i]) mdl_idx = i;
            mdl_r = m_ovr_en ? m_ovr_res : unit_fn(mdl_idx, unit_a, unit_b);
            unit_res = {$urandom, $urandom, $urandom};
            if (m_lat >= 2) begin
                @(posedge clk); #1 unit_done[(mdl_idx + 1) % NU] = 1'b1;
                @(posedge clk); #1 unit_done = '0;
                repeat (m_lat - 2) @(posedge clk);
            end else begin
                repeat (m_lat) @(posedge clk);
            end
            #1;
            unit_res[16*mdl_idx +: 16] = mdl_r;
            unit_done[mdl_idx] = 1'b1;
            @(posedge clk); #1 unit_done = '0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: done arrives lat+1 WAIT cycles after the start pulse; the
    // watchdog fires on WAIT cycle TO-1, i.e. TO edges after accept.
    task automatic ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int lat,
                           output logic [15:0] res, output logic zero, output logic neg,
                           output logic err, output int elat);
        res = '0; zero = 1'b0; neg = 1'b0; err = 1'b0; elat = 0;
        if (int'(op) >= NU) begin
            err = 1'b1;
        end else if (lat == NEVER || lat + 1 > TO - 1) begin
            err = 1'b1; elat = TO;
        end else begin
            res = unit_fn(int'(op), a, b);
            zero = (res == 16'd0); neg = res[15]; elat = lat + 2;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int lat,
                          input logic ovr_en, input logic [15:0] ovr_res,
                          input logic [15:0] e_res, input logic e_zero, input logic e_neg,
                          input logic e_err, input int e_lat, input int bp);
        int n = 0, start_cnt = 0, w = 0;
        logic bad_start = 1'b0, opnd_bad = 1'b0, stable = 1'b1;
        logic [18:0] held;
        logic [NU-1:0] exp_oh = (int'(op) < NU) ? NU'(1 << op) : '0;
        while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
        chk("req_ready_before", 64'(req_ready), 64'd1);
        m_lat = lat; m_ovr_en = ovr_en; m_ovr_res = ovr_res;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = ~a; req_b = ~b;
        while (1) begin
            if (unit_start != '0) begin
                start_cnt++;
                if (unit_start != exp_oh) bad_start = 1'b1;
            end
            if (unit_a != a || unit_b != b || req_ready) opnd_bad = 1'b1;
            if (rsp_valid || n >= 60) break;
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(e_lat));
        chk("start_count", 64'(start_cnt), (int'(op) < NU) ? 64'd1 : 64'd0);
        chk("start_onehot", 64'(bad_start), 64'd0);
        chk("operand_hold", 64'(opnd_bad), 64'd0);
        chk("rsp_res", 64'(rsp_res), 64'(e_res));
        chk("rsp_flags", 64'({rsp_zero, rsp_neg, rsp_err}), 64'({e_zero, e_neg, e_err}));
        held = {rsp_res, rsp_zero, rsp_neg, rsp_err};
        repeat (bp) begin
            @(posedge clk); #1;
            if (held != {rsp_res, rsp_zero, rsp_neg, rsp_err} || !rsp_valid || req_ready) stable = 1'b0;
        end
        chk("backpressure_hold", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("handshake", 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic        ovr_en;
        logic [15:0] ovr_res;
        logic [15:0] e_res;
        logic        e_zero;
        logic        e_neg;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] r_res;
        logic        r_zero, r_neg, r_err;
        int          r_lat, lat, sel, n;
        logic [2:0]  op;
        logic [7:0]  a, b;
        logic        quiet;

        tbl[0] = '{3'd0, 8'hF0, 8'h3C, 3,     1'b0, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b0, 5};
        tbl[1] = '{3'd0, 8'h0F, 8'hF0, 3,     1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
        tbl[2] = '{3'd1, 8'h12, 8'h34, 3,     1'b1, 16'h8001, 16'h8001, 1'b0, 1'b1, 1'b0, 5};
        tbl[3] = '{3'd7, 8'hAA, 8'h55, 3,     1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0};
        tbl[4] = '{3'd6, 8'h01, 8'h02, 3,     1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0};
        tbl[5] = '{3'd3, 8'h5A, 8'h5A, NEVER, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16};
        tbl[6] = '{3'd4, 8'h11, 8'h22, 15,    1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16};
        tbl[7] = '{3'd2, 8'hFF, 8'hFF, 14,    1'b0, 16'h0000, 16'h01FE, 1'b0, 1'b0, 1'b0, 16};
        tbl[8] = '{3'd5, 8'hFF, 8'hFF, 1,     1'b0, 16'h0000, 16'hFE01, 1'b0, 1'b1, 1'b0, 3};
        tbl[9] = '{3'd4, 8'h03, 8'h05, 2,     1'b0, 16'h0000, 16'hFFFE, 1'b0, 1'b1, 1'b0, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {21'd0, req_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_res, rsp_zero, rsp_neg, rsp_err},
            {21'd0, 1'b1, 6'd0, 8'd0, 8'd0, 1'b0, 16'd0, 3'd0});
        reset = 1'b1;

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].ovr_en, tbl[i].ovr_res,
                   tbl[i].e_res, tbl[i].e_zero, tbl[i].e_neg, tbl[i].e_err, tbl[i].e_lat, 10);

        // Asynchronous reset in WAIT; the abandoned unit's later done must be ignored.
        m_lat = 6; m_ovr_en = 1'b0;
        req_valid = 1'b1; req_op = 3'd2; req_a = 8'h77; req_b = 8'h22;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_before_reset", 64'({req_ready, rsp_valid}), 64'b00);
        #3 reset = 1'b0;
        #1;
        chk("async_reset", {21'd0, req_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_res, rsp_zero, rsp_neg, rsp_err},
            {21'd0, 1'b1, 6'd0, 8'd0, 8'd0, 1'b0, 16'd0, 3'd0});
        @(posedge clk); #1 reset = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid || !req_ready || unit_start != '0) quiet = 1'b0;
        end
        chk("stale_done_ignored", 64'(quiet), 64'd1);
        run_op(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].lat, 1'b0, 16'h0, tbl[0].e_res,
               tbl[0].e_zero, tbl[0].e_neg, tbl[0].e_err, tbl[0].e_lat, 2);

        for (int k = 0; k < 40; k++) begin
            op  = 3'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            sel = $urandom_range(0, 9);
            lat = (sel < 7) ? $urandom_range(1, 6) : (sel == 7) ? NEVER : $urandom_range(13, 15);
            ref_rsp(op, a, b, lat, r_res, r_zero, r_neg, r_err, r_lat);
            n = $urandom_range(0, 3);
            run_op(op, a, b, lat, 1'b0, 16'h0, r_res, r_zero, r_neg, r_err, r_lat, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
